// File: rtl/i2c_target.sv
// I2C target with a 16-bit register interface: address match, byte receive
// with ACK/NACK, byte transmit, level interrupt.
// Ports: Clk, ResetN (async, active low)
//        Addr, DataRd, DataWr, En, Rd, Wr : register bus
//        SdaIn, SclIn : pin levels
//        SdaOut       : open-drain, 1 pulls SDA low
//        IntStatus    : level interrupt
module i2c_target #(
    parameter logic [6:0] OWN_ADDR = 7'h50
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [2:0]  Addr,
    output logic [15:0] DataRd,
    input  logic [15:0] DataWr,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        SdaIn,
    input  logic        SclIn,
    output logic        SdaOut,
    output logic        IntStatus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT_STOP
    } stateT;

    stateT state;
    stateT stateNext;

    // Pin synchronizers plus a history flop for edge detection.
    logic sdaS1;
    logic sdaS2;
    logic sdaPrev;
    logic sclS1;
    logic sclS2;
    logic sclPrev;

    logic sclRise;
    logic sclFall;
    logic startEv;
    logic stopEv;

    // Registers and flags.
    logic       rxValid;
    logic       txEmpty;
    logic       busy;
    logic       rxOverrun;
    logic       txUnderrun;
    logic       stopSeen;
    logic       readMode;
    logic       ctrlEnable;
    logic       ctrlIntEn;
    logic [7:0] rxData;
    logic [7:0] txData;

    // Shift datapath.
    logic [7:0] rxShift;
    logic [7:0] txShift;
    logic [3:0] bitCnt;
    logic       cntActive;
    logic       rxActive;

    // Control strobes from the next-state logic.
    logic clrCnt;
    logic loadRx;
    logic setOvr;
    logic loadTx;
    logic addrMatch;
    logic addrMiss;

    // Register bus decode.
    logic wrEn;
    logic rdEn;
    logic wrStatus;
    logic wrTxData;
    logic wrCtrl;
    logic rdRxData;

    logic unusedDataWr;

    assign unusedDataWr = ^DataWr[15:8];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            sdaS1   <= 1'b1;
            sdaS2   <= 1'b1;
            sdaPrev <= 1'b1;
            sclS1   <= 1'b1;
            sclS2   <= 1'b1;
            sclPrev <= 1'b1;
        end else begin
            sdaS1   <= SdaIn;
            sdaS2   <= sdaS1;
            sdaPrev <= sdaS2;
            sclS1   <= SclIn;
            sclS2   <= sclS1;
            sclPrev <= sclS2;
        end
    end

    assign sclRise = sclS2 & ~sclPrev;
    assign sclFall = ~sclS2 & sclPrev;
    // SCL must be high on both samples so an SCL edge never looks like a
    // bus condition.
    assign startEv = sclS2 & sclPrev & sdaPrev & ~sdaS2;
    assign stopEv  = sclS2 & sclPrev & ~sdaPrev & sdaS2;

    assign wrEn     = En & Wr;
    assign rdEn     = En & Rd;
    assign wrStatus = wrEn & (Addr == 3'd0);
    assign wrTxData = wrEn & (Addr == 3'd2);
    assign wrCtrl   = wrEn & (Addr == 3'd3);
    assign rdRxData = rdEn & (Addr == 3'd1);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        clrCnt    = 1'b0;
        loadRx    = 1'b0;
        setOvr    = 1'b0;
        loadTx    = 1'b0;
        addrMatch = 1'b0;
        addrMiss  = 1'b0;
        if (!ctrlEnable) begin
            stateNext = IDLE;
        end else if (stopEv) begin
            stateNext = IDLE;
        end else if (startEv) begin
            stateNext = ADDR;
            clrCnt    = 1'b1;
        end else begin
            unique case (state)
                ADDR: begin
                    if (sclFall && bitCnt == 4'd8) begin
                        clrCnt = 1'b1;
                        if (rxShift[7:1] == OWN_ADDR) begin
                            addrMatch = 1'b1;
                            stateNext = ADDR_ACK;
                        end else begin
                            addrMiss  = 1'b1;
                            stateNext = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        clrCnt = 1'b1;
                        if (readMode) begin
                            loadTx    = 1'b1;
                            stateNext = TX;
                        end else begin
                            stateNext = RX;
                        end
                    end
                end
                RX: begin
                    if (sclFall && bitCnt == 4'd8) begin
                        clrCnt = 1'b1;
                        if (!rxValid) begin
                            loadRx    = 1'b1;
                            stateNext = RX_ACK;
                        end else begin
                            setOvr    = 1'b1;
                            stateNext = WAIT_STOP;
                        end
                    end
                end
                RX_ACK: begin
                    if (sclFall) begin
                        clrCnt    = 1'b1;
                        stateNext = RX;
                    end
                end
                TX: begin
                    if (sclFall && bitCnt == 4'd8) begin
                        clrCnt    = 1'b1;
                        stateNext = TX_ACK;
                    end
                end
                TX_ACK: begin
                    // The 9th rise comes before the fall that leaves this
                    // state, so reaching the fall means the master ACKed.
                    if (sclRise && sdaS2) begin
                        stateNext = WAIT_STOP;
                    end else if (sclFall) begin
                        clrCnt    = 1'b1;
                        loadTx    = 1'b1;
                        stateNext = TX;
                    end
                end
                default: begin
                    stateNext = state;
                end
            endcase
        end
    end

    assign cntActive = (state == ADDR) | (state == RX) | (state == TX);
    assign rxActive  = (state == ADDR) | (state == RX);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            bitCnt  <= 4'd0;
            rxShift <= 8'd0;
            txShift <= 8'hFF;
        end else begin
            if (clrCnt) begin
                bitCnt <= 4'd0;
            end else if (sclRise && cntActive && bitCnt != 4'd8) begin
                bitCnt <= bitCnt + 4'd1;
            end
            if (sclRise && rxActive && bitCnt != 4'd8) begin
                rxShift <= {rxShift[6:0], sdaS2};
            end
            if (loadTx) begin
                txShift <= txEmpty ? 8'hFF : txData;
            end else if (sclFall && state == TX && bitCnt != 4'd8) begin
                txShift <= {txShift[6:0], 1'b1};
            end
        end
    end

    // Where a bus write and a hardware event hit the same flag in one cycle,
    // the hardware set takes priority, except TxEmpty where the new TXDATA
    // write leaves it cleared.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            rxValid    <= 1'b0;
            txEmpty    <= 1'b1;
            busy       <= 1'b0;
            rxOverrun  <= 1'b0;
            txUnderrun <= 1'b0;
            stopSeen   <= 1'b0;
            readMode   <= 1'b0;
            ctrlEnable <= 1'b0;
            ctrlIntEn  <= 1'b0;
            rxData     <= 8'd0;
            txData     <= 8'd0;
        end else begin
            if (loadRx) begin
                rxData  <= rxShift;
                rxValid <= 1'b1;
            end else if (rdRxData) begin
                rxValid <= 1'b0;
            end

            if (wrTxData) begin
                txData <= DataWr[7:0];
            end

            if (wrTxData) begin
                txEmpty <= 1'b0;
            end else if (loadTx) begin
                txEmpty <= 1'b1;
            end

            if (loadTx && txEmpty) begin
                txUnderrun <= 1'b1;
            end else if (wrStatus && DataWr[4]) begin
                txUnderrun <= 1'b0;
            end

            if (setOvr) begin
                rxOverrun <= 1'b1;
            end else if (wrStatus && DataWr[3]) begin
                rxOverrun <= 1'b0;
            end

            if (stopEv && busy) begin
                stopSeen <= 1'b1;
            end else if (wrStatus && DataWr[5]) begin
                stopSeen <= 1'b0;
            end

            if (addrMatch) begin
                busy <= 1'b1;
            end else if (addrMiss || stopEv) begin
                busy <= 1'b0;
            end

            if (addrMatch) begin
                readMode <= rxShift[0];
            end else if (addrMiss) begin
                readMode <= 1'b0;
            end

            if (wrCtrl) begin
                ctrlEnable <= DataWr[0];
                ctrlIntEn  <= DataWr[1];
            end
        end
    end

    always_comb begin
        DataRd = 16'd0;
        unique case (Addr)
            3'd0: DataRd = {9'd0, readMode, stopSeen, txUnderrun,
                            rxOverrun, busy, txEmpty, rxValid};
            3'd1: DataRd = {8'd0, rxData};
            3'd2: DataRd = {8'd0, txData};
            3'd3: DataRd = {14'd0, ctrlIntEn, ctrlEnable};
            default: DataRd = 16'd0;
        endcase
    end

    // Gated by Enable so clearing it releases SDA without waiting a cycle.
    always_comb begin
        SdaOut = 1'b0;
        if (ctrlEnable) begin
            unique case (state)
                ADDR_ACK: SdaOut = 1'b1;
                RX_ACK:   SdaOut = 1'b1;
                TX:       SdaOut = ~txShift[7];
                default:  SdaOut = 1'b0;
            endcase
        end
    end

    assign IntStatus = ctrlIntEn &
                       (rxValid | stopSeen | rxOverrun | txUnderrun);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-master model, register access, scoreboard.
module tb_i2c_target;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [2:0]  Addr = 3'd0;
    logic [15:0] DataWr = 16'd0;
    logic        En = 1'b0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic        sdaM = 1'b1;
    logic        sclM = 1'b1;
    logic [15:0] DataRd;
    logic        SdaOut;
    logic        IntStatus;
    wire         sdaLine = sdaM & ~SdaOut;

    i2c_target dut (
        .Clk(Clk),
        .ResetN(ResetN),
        .Addr(Addr),
        .DataRd(DataRd),
        .DataWr(DataWr),
        .En(En),
        .Rd(Rd),
        .Wr(Wr),
        .SdaIn(sdaLine),
        .SclIn(sclM),
        .SdaOut(SdaOut),
        .IntStatus(IntStatus)
    );

    always #5 Clk = ~Clk;

    logic [15:0] expQ[$];
    string       nameQ[$];
    logic        obsStrobe = 1'b0;
    logic [15:0] obsVal = 16'd0;
    int          checks = 0;
    int          failures = 0;

    logic sawLow = 1'b0;
    logic clrSaw = 1'b0;

    always @(posedge Clk) begin
        if (clrSaw) sawLow <= 1'b0;
        else if (SdaOut) sawLow <= 1'b1;
    end

    always @(posedge Clk) begin
        if (obsStrobe) begin
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected: got %h, nothing expected", obsVal);
            end else begin
                logic [15:0] e;
                string n;
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checks++;
                if (obsVal !== e) begin
                    failures++;
                    $display("FAIL %s: got %h want %h", n, obsVal, e);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expectVal(input string n, input logic [15:0] v);
        nameQ.push_back(n);
        expQ.push_back(v);
    endtask

    task automatic present(input logic [15:0] v);
        @(negedge Clk);
        obsVal = v;
        obsStrobe = 1'b1;
        @(negedge Clk);
        obsStrobe = 1'b0;
    endtask

    task automatic quarter();
        repeat (8) @(posedge Clk);
    endtask

    task automatic regWrite(input logic [2:0] a, input logic [15:0] d);
        @(negedge Clk);
        Addr = a;
        DataWr = d;
        En = 1'b1;
        Wr = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        Wr = 1'b0;
    endtask

    task automatic regRead(input logic [2:0] a, output logic [15:0] d);
        @(negedge Clk);
        Addr = a;
        En = 1'b1;
        Rd = 1'b1;
        #1 d = DataRd;
        @(negedge Clk);
        En = 1'b0;
        Rd = 1'b0;
    endtask

    task automatic busStart();
        sdaM = 1'b1;
        sclM = 1'b1;
        quarter();
        sdaM = 1'b0;
        quarter();
        sclM = 1'b0;
        quarter();
    endtask

    task automatic busRestart();
        sdaM = 1'b1;
        quarter();
        sclM = 1'b1;
        quarter();
        sdaM = 1'b0;
        quarter();
        sclM = 1'b0;
        quarter();
    endtask

    task automatic busStop();
        sdaM = 1'b0;
        quarter();
        sclM = 1'b1;
        quarter();
        sdaM = 1'b1;
        quarter();
        repeat (4) @(posedge Clk);
    endtask

    task automatic writeBit(input logic b);
        sdaM = b;
        quarter();
        sclM = 1'b1;
        quarter();
        quarter();
        sclM = 1'b0;
        quarter();
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1;
        quarter();
        sclM = 1'b1;
        quarter();
        b = sdaLine;
        quarter();
        sclM = 1'b0;
        quarter();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        writeBit(nack);
    endtask

    initial begin
        logic [15:0] r;
        logic        a;
        logic [7:0]  d;
        logic        v;

        // Reset state.
        repeat (3) @(posedge Clk);
        expectVal("rstSdaOut", 16'h0000);
        present({15'd0, SdaOut});
        expectVal("rstStatus", 16'h0002);
        regRead(3'd0, r);
        present(r);
        expectVal("rstInt", 16'h0000);
        present({15'd0, IntStatus});
        ResetN = 1'b1;
        repeat (3) @(posedge Clk);

        // Write transaction.
        regWrite(3'd3, 16'h0003);
        busStart();
        expectVal("wrAddrAck", 16'h0000);
        writeByte(8'hA0, a);
        present({15'd0, a});
        expectVal("wrDataAck", 16'h0000);
        writeByte(8'h5A, a);
        present({15'd0, a});
        busStop();
        expectVal("wrStatus", 16'h0023);
        regRead(3'd0, r);
        present(r);
        expectVal("wrInt", 16'h0001);
        present({15'd0, IntStatus});
        expectVal("wrRxData", 16'h005A);
        regRead(3'd1, r);
        present(r);

        // Overrun.
        regWrite(3'd0, 16'h0020);
        busStart();
        expectVal("ovAddrAck", 16'h0000);
        writeByte(8'hA0, a);
        present({15'd0, a});
        expectVal("ovAck11", 16'h0000);
        writeByte(8'h11, a);
        present({15'd0, a});
        expectVal("ovNack22", 16'h0001);
        writeByte(8'h22, a);
        present({15'd0, a});
        busStop();
        expectVal("ovStatus", 16'h002B);
        regRead(3'd0, r);
        present(r);
        expectVal("ovRxData", 16'h0011);
        regRead(3'd1, r);
        present(r);
        regWrite(3'd0, 16'h0038);
        expectVal("w1cStatus", 16'h0002);
        regRead(3'd0, r);
        present(r);

        // Read transaction.
        regWrite(3'd2, 16'h00C3);
        expectVal("txLoadedStatus", 16'h0000);
        regRead(3'd0, r);
        present(r);
        busStart();
        expectVal("rdAddrAck", 16'h0000);
        writeByte(8'hA1, a);
        present({15'd0, a});
        expectVal("rdByte", 16'h00C3);
        readByte(1'b1, d);
        present({8'd0, d});
        busStop();
        expectVal("rdStatus", 16'h0062);
        regRead(3'd0, r);
        present(r);
        expectVal("txReadback", 16'h00C3);
        regRead(3'd2, r);
        present(r);

        // Underrun.
        regWrite(3'd0, 16'h0020);
        busStart();
        expectVal("urAddrAck", 16'h0000);
        writeByte(8'hA1, a);
        present({15'd0, a});
        expectVal("urByte", 16'h00FF);
        readByte(1'b0, d);
        present({8'd0, d});
        busStop();
        expectVal("urStatus", 16'h0072);
        regRead(3'd0, r);
        present(r);
        regWrite(3'd0, 16'h0030);

        // Address mismatch.
        @(negedge Clk);
        clrSaw = 1'b1;
        @(negedge Clk);
        clrSaw = 1'b0;
        busStart();
        expectVal("missNack", 16'h0001);
        writeByte(8'hA2, a);
        present({15'd0, a});
        expectVal("missStatusMid", 16'h0002);
        regRead(3'd0, r);
        present(r);
        busStop();
        expectVal("missSdaLow", 16'h0000);
        present({15'd0, sawLow});
        expectVal("missStatus", 16'h0002);
        regRead(3'd0, r);
        present(r);
        expectVal("missInt", 16'h0000);
        present({15'd0, IntStatus});

        // Repeated START, then reset mid-byte.
        regWrite(3'd2, 16'h0096);
        busStart();
        expectVal("srAddrAck", 16'h0000);
        writeByte(8'hA0, a);
        present({15'd0, a});
        expectVal("srDataAck", 16'h0000);
        writeByte(8'h01, a);
        present({15'd0, a});
        busRestart();
        expectVal("srReadAck", 16'h0000);
        writeByte(8'hA1, a);
        present({15'd0, a});
        expectVal("srStatus", 16'h0047);
        regRead(3'd0, r);
        present(r);
        expectVal("srBit7", 16'h0001);
        readBit(v);
        present({15'd0, v});
        expectVal("srBit6", 16'h0000);
        readBit(v);
        present({15'd0, v});
        expectVal("srSdaDriven", 16'h0001);
        present({15'd0, SdaOut});
        expectVal("srResetRelease", 16'h0000);
        ResetN = 1'b0;
        #1 v = SdaOut;
        present({15'd0, v});
        ResetN = 1'b1;
        sdaM = 1'b1;
        sclM = 1'b1;
        repeat (4) @(posedge Clk);

        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
